// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state, sync byte and error codes for the UART frame parser
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CHK     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    // A length byte is usable when it is non-zero and fits the payload buffer.
    function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload buffer, synchronous write and asynchronous read, no reset
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] mem [MAX_LEN];

    // Payload bytes land here as they are received.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - sync/length/payload/checksum framer replaying good frames as a byte stream
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 21700
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_byte,
    output logic       o_data_valid,
    output logic [7:0] o_data_byte,
    output logic       o_data_last,
    input  logic       i_data_ready,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic       o_overrun
);

    localparam int PTR_W  = $clog2(MAX_LEN + 1);
    localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             prev_valid_q;
    logic [7:0]       len_q;
    logic [7:0]       sum_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [TO_W-1:0]  idle_q;
    logic             err_q;
    err_t             err_code_q;
    logic             overrun_q;

    logic             rx_stb;
    logic             in_frame;
    logic             drain;
    logic             timeout_hit;
    logic             beat_xfer;
    logic             last_beat;
    logic             pay_done;
    logic             len_good;
    logic             chk_ok;
    logic [7:0]       chk_sum;
    logic [7:0]       buf_rdata;
    logic             err_fire;
    err_t             err_cause;

    // A held-high valid counts once: only its rising edge is a byte.
    assign rx_stb      = i_rx_valid & ~prev_valid_q;
    assign in_frame    = state_q inside {ST_LEN, ST_PAYLOAD, ST_CHK};
    assign drain       = (state_q == ST_DRAIN);
    // A byte arriving in the same cycle pre-empts the timeout.
    assign timeout_hit = in_frame && !rx_stb && (idle_q == TO_LAST);
    assign beat_xfer   = drain && i_data_ready;
    assign last_beat   = (8'(rd_ptr_q) == (len_q - 8'd1));
    assign pay_done    = (8'(wr_ptr_q) == (len_q - 8'd1));
    assign len_good    = len_ok(i_rx_byte, MAX_LEN_B);
    assign chk_sum     = sum_q + i_rx_byte;
    assign chk_ok      = (chk_sum == 8'd0);

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (BUF_AW)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    ((state_q == ST_PAYLOAD) && rx_stb),
        .i_waddr (wr_ptr_q[BUF_AW-1:0]),
        .i_wdata (i_rx_byte),
        .i_raddr (rd_ptr_q[BUF_AW-1:0]),
        .o_rdata (buf_rdata)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the rejection cause that goes with each error transition.
    always_comb begin
        state_d   = state_q;
        err_fire  = 1'b0;
        err_cause = ERR_NONE;
        case (state_q)
            ST_HUNT: begin
                if (rx_stb && (i_rx_byte == SYNC_BYTE)) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (rx_stb) begin
                    if (len_good) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        state_d   = ST_HUNT;
                        err_fire  = 1'b1;
                        err_cause = ERR_LEN;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_stb && pay_done) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (rx_stb) begin
                    if (chk_ok) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d   = ST_HUNT;
                        err_fire  = 1'b1;
                        err_cause = ERR_CHK;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat_xfer && last_beat) state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase
        if (timeout_hit) begin
            state_d   = ST_HUNT;
            err_fire  = 1'b1;
            err_cause = ERR_TIMEOUT;
        end
    end

    // Frame datapath: length, running sum, pointers, idle counter and event pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_valid_q <= 1'b0;
            len_q        <= 8'd0;
            sum_q        <= 8'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            idle_q       <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            overrun_q    <= 1'b0;
        end else begin
            prev_valid_q <= i_rx_valid;
            err_q        <= err_fire;
            err_code_q   <= err_fire ? err_cause : ERR_NONE;
            overrun_q    <= drain && rx_stb;
            if (in_frame && !rx_stb && !timeout_hit) begin
                idle_q <= idle_q + TO_W'(1);
            end else begin
                idle_q <= '0;
            end
            case (state_q)
                ST_LEN: begin
                    if (rx_stb && len_good) begin
                        len_q    <= i_rx_byte;
                        sum_q    <= i_rx_byte;
                        wr_ptr_q <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_stb) begin
                        sum_q    <= sum_q + i_rx_byte;
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    end
                end
                ST_CHK: begin
                    if (rx_stb && chk_ok) rd_ptr_q <= '0;
                end
                ST_DRAIN: begin
                    if (beat_xfer) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs; the data byte is forced to zero outside DRAIN so stale buffer contents never leak.
    always_comb begin
        o_data_valid = drain;
        o_data_byte  = drain ? buf_rdata : 8'd0;
        o_data_last  = drain && last_beat;
        o_frame_err  = err_q;
        o_err_code   = err_code_q;
        o_overrun    = overrun_q;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Consumes the byte stream produced by the UART receiver and extracts framed commands: hunts for a sync byte, reads a length, buffers the payload, and verifies a checksum. Each good frame is replayed on a valid/ready byte stream with a last flag to the command logic downstream. Bad frames are discarded and flagged. The block has no backpressure toward the receiver, so bytes that arrive while a frame is draining are dropped and reported.

## Interface
- MAX_LEN, 16, maximum payload bytes per frame; legal range 1..255
- TIMEOUT_CYCLES, 21700, inter-byte idle limit inside a frame, in clock cycles; this is 10 byte times at 217 cycles/bit
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; one clock, asynchronous assert, active-low
- i_rx_valid  in  1  byte-valid from the UART receiver; may be held high for many cycles per byte
- i_rx_byte  in  8  received byte; stable while i_rx_valid is high
- o_data_valid  out  1  payload beat available
- o_data_byte  out  8  payload byte
- o_data_last  out  1  high on the final payload beat of a frame
- i_data_ready  in  1  downstream accepts the beat
- o_frame_err  out  1  one-cycle pulse when a frame is rejected
- o_err_code  out  2  error cause while o_frame_err is high, else 0: 1 = bad length, 2 = bad checksum, 3 = timeout
- o_overrun  out  1  one-cycle pulse when a byte is dropped during DRAIN

## Operation
- **Byte strobe:** a byte is accepted only on a rising edge of i_rx_valid, i.e. i_rx_valid=1 and its registered previous value is 0. i_rx_byte is sampled in that cycle. Holding i_rx_valid high counts as one byte.
- **Frame format:** 0xA5, LEN, LEN payload bytes, CHK. A frame is good when (LEN + sum of payload + CHK) mod 256 = 0.
- **States:** HUNT, LEN, PAYLOAD, CHK, DRAIN.
- **HUNT:** an accepted 0xA5 moves to LEN. Any other byte is ignored silently.
- **LEN:**
  - A byte of 0 or greater than MAX_LEN pulses o_frame_err with code 1 and returns to HUNT. That byte is never re-examined as a sync byte.
  - Otherwise store the length, seed the running sum with it, clear the write pointer, and go to PAYLOAD.
- **PAYLOAD:** write each byte to buffer[wr_ptr], add it to the sum, and increment the pointer. After the LEN-th byte, go to CHK.
- **CHK:** if (sum + byte) mod 256 = 0, go to DRAIN with the read pointer at 0. Otherwise pulse o_frame_err with code 2 and go to HUNT.
- **DRAIN:**
  - o_data_valid=1 and o_data_byte=buffer[rd_ptr]; o_data_last=1 when rd_ptr = LEN-1.
  - A beat transfers when o_data_valid and i_data_ready are both high; the pointer then increments.
  - The transfer of the last beat returns to HUNT.
  - Any byte accepted in DRAIN, including 0xA5, is dropped and pulses o_overrun.
- **Timeout:** in LEN, PAYLOAD and CHK an idle counter clears on every accepted byte and increments otherwise. When it reaches TIMEOUT_CYCLES-1, pulse o_frame_err with code 3 and go to HUNT. The counter is idle in HUNT and DRAIN.
- **Arithmetic:** the sum is 8-bit and wraps. The pointers are $clog2(MAX_LEN+1) bits wide. LEN is compared against MAX_LEN at 8 bits.

## Timing
- **Reset values:** state HUNT, all outputs 0, pointers and sum 0, previous-valid register 0. The buffer contents are don't-care.
- **Reset mid-frame or mid-drain:** the frame is discarded, outputs drop to 0 asynchronously, and no error pulse is generated.
- **Latency:** o_data_valid rises in the cycle after the CHK byte's accept cycle.
- **Throughput:** one beat per cycle while i_data_ready is held high, with no bubbles.
- **Stability:** while o_data_valid=1 and i_data_ready=0, o_data_byte and o_data_last hold stable.
- **Error and overrun pulses:** o_frame_err and o_overrun are registered and high in the cycle after the causing event, for exactly one cycle.
- **Byte vs. timeout in the same cycle:** the byte wins. The counter clears, the byte is processed, and no timeout fires.
- **Last beat and byte edge in the same cycle:** the byte is dropped with o_overrun, because the state is still DRAIN.

## Structure
- **Shared package uart_frame_pkg:**
  - state encoding, 3 bits: HUNT=0, LEN=1, PAYLOAD=2, CHK=3, DRAIN=4
  - SYNC_BYTE = 8'hA5
  - error codes: ERR_NONE=0, ERR_LEN=1, ERR_CHK=2, ERR_TIMEOUT=3
- **Sub-module uart_frame_buf:** MAX_LEN x 8 storage with one synchronous write port and one asynchronous read port. It has no reset.

## Test plan
- **Good frame:** A5 03 01 02 03 F7, i_data_ready=1. Expect three consecutive beats 01, 02, 03; o_data_last only on 03; no error.
- **Backpressure:** same frame with i_data_ready toggling 0/1. Expect each beat held stable until accepted, order preserved, o_data_last on 03.
- **Bad checksum:** A5 02 10 20 00. Expect o_frame_err with code 2 and no o_data_valid. A following good frame A5 01 55 AA is delivered as one beat 55 with last.
- **Bad length and junk:** bytes 00 A5 00 A5 11 with MAX_LEN=16. Expect the first 00 ignored, code 1 for LEN=00, then code 1 for LEN=0x11. The 00 in LEN position is not treated as sync.
- **Timeout:** A5 02 33, then idle for TIMEOUT_CYCLES. Expect code 3 exactly once, then HUNT.
- **Overrun and reset:**
  - i_rx_valid is held high across 100 cycles per byte, so each byte counts once.
  - A5 anywhere during DRAIN gives o_overrun with no frame start.
  - Asserting i_rst_n low mid-PAYLOAD zeroes all outputs immediately.
